// File: rtl/cpu_seq.sv
// Instruction sequencer for the 16-bit RISC core: IR, PC, data-address register and control FSM.
// Optional macro CPU_SEQ_MEM_TIMEOUT_EN adds a per-access wait-state timeout leading to a sticky FAULT state.
//
// state | meaning
// RST   | post-reset idle, one cycle
// IF1   | fetch, wait for mem_ready
// IF2   | fetch data capture into ir
// UPC   | pc increment
// DEC   | opcode dispatch
// WIMM  | write sximm8 to Rn
// GA/GB | load A from Rn, B from Rm
// GB0   | load B only (MOV reg / MVN)
// EX    | ALU op into C, update status
// EX0   | C = 0 op B
// CMP   | status update only
// WB    | write C to Rd
// GA3   | load A from Rn (LDR/STR)
// AD3   | C = Rn + sximm5
// LA    | latch data address from C
// RD/LW | memory read, then write mdata to Rd
// GD/CD | load B from Rd, C = Rd
// WR    | memory write
// BR    | conditional pc update
// HALT  | stopped until reset
// FAULT | memory timeout, sticky (optional)
module cpu_seq #(
  parameter int                ADDR_W      = 9,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       read_data,
  input  logic              mem_ready,
  input  logic [15:0]       datapath_out,
  input  logic              N,
  input  logic              V,
  input  logic              Z,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic              loadc,
  output logic              loads,
  output logic [1:0]        vsel,
  output logic [2:0]        nsel,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GA, S_GB, S_GB0, S_EX, S_EX0,
    S_CMP, S_WB, S_GA3, S_AD3, S_LA, S_RD, S_LW, S_GD, S_CD, S_WR, S_BR, S_HALT
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  typedef struct packed {
    logic [1:0] mem_cmd;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic       halted;
    logic       fault;
  } ctl_t;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM  = 2'b10;
  localparam logic [1:0] VSEL_MEM  = 2'b11;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RM   = 3'b010;
  localparam logic [2:0] NSEL_RD   = 3'b100;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  ctl_t              ctl_q, ctl_d;
  logic [15:0]       sximm8;
  logic              br_taken;
  logic              waiting;

  logic [2:0] opcode, cond;
  logic [1:0] op;
  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign cond   = ir_q[10:8];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign waiting = (state_q == S_IF1) || (state_q == S_RD) || (state_q == S_WR);

`ifdef CPU_SEQ_MEM_TIMEOUT_EN
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_IF1, S_IF2, S_RD: c.mem_cmd = CMD_READ;
      S_WR:               c.mem_cmd = CMD_WRITE;
      S_WIMM:             begin c.write = 1'b1; c.nsel = NSEL_RN; c.vsel = VSEL_IMM; end
      S_GA, S_GA3:        begin c.loada = 1'b1; c.nsel = NSEL_RN; end
      S_GB, S_GB0:        begin c.loadb = 1'b1; c.nsel = NSEL_RM; end
      S_EX:               begin c.loadc = 1'b1; c.loads = 1'b1; end
      S_EX0, S_CD:        begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_CMP:              c.loads = 1'b1;
      S_WB:               begin c.write = 1'b1; c.vsel = VSEL_C; c.nsel = NSEL_RD; end
      S_AD3:              begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LW:               begin c.write = 1'b1; c.vsel = VSEL_MEM; c.nsel = NSEL_RD; end
      S_GD:               begin c.loadb = 1'b1; c.nsel = NSEL_RD; end
      S_HALT:             c.halted = 1'b1;
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
      S_FAULT:            begin c.halted = 1'b1; c.fault = 1'b1; end
`endif
      default:            c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = Z;
      3'b010:  br_taken = !Z;
      3'b011:  br_taken = N ^ V;
      3'b100:  br_taken = (N ^ V) | Z;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  if (mem_ready) state_d = S_IF2;
      S_IF2:  begin ir_d = read_data; state_d = S_UPC; end
      S_UPC:  begin pc_d = pc_q + ADDR_W'(1); state_d = S_DEC; end
      S_DEC: begin
        case (opcode)
          3'b110: begin
            if (op == 2'b10)      state_d = S_WIMM;
            else if (op == 2'b00) state_d = S_GB0;
            else                  state_d = S_IF1;
          end
          3'b101:         state_d = (op == 2'b11) ? S_GB0 : S_GA;
          3'b011, 3'b100: state_d = (op == 2'b00) ? S_GA3 : S_IF1;
          3'b001:         state_d = S_BR;
          3'b111:         state_d = S_HALT;
          default:        state_d = S_IF1;
        endcase
      end
      S_WIMM: state_d = S_IF1;
      S_GA:   state_d = S_GB;
      S_GB:   state_d = (op == 2'b01) ? S_CMP : S_EX;
      S_GB0:  state_d = S_EX0;
      S_EX:   state_d = S_WB;
      S_EX0:  state_d = S_WB;
      S_CMP:  state_d = S_IF1;
      S_WB:   state_d = S_IF1;
      S_GA3:  state_d = S_AD3;
      S_AD3:  state_d = S_LA;
      S_LA: begin
        addr_d  = datapath_out[ADDR_W-1:0];
        state_d = (opcode == 3'b011) ? S_RD : S_GD;
      end
      S_RD:   if (mem_ready) state_d = S_LW;
      S_LW:   state_d = S_IF1;
      S_GD:   state_d = S_CD;
      S_CD:   state_d = S_WR;
      S_WR:   if (mem_ready) state_d = S_IF1;
      S_BR: begin
        if (br_taken) pc_d = pc_q + sximm8[ADDR_W-1:0];
        state_d = S_IF1;
      end
      S_HALT: state_d = S_HALT;
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_RST;
    endcase
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
    // Counter only runs while an access is stalled; any exit or fresh entry sees zero.
    cnt_d = '0;
    if (waiting && !mem_ready) begin
      if (cnt_q == CNT_LAST) state_d = S_FAULT;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
`endif
    ctl_d = decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      ir_q    <= '0;
      ctl_q   <= '0;
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
`ifdef CPU_SEQ_MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ir       = ir_q;
  assign pc       = pc_q;
  assign mem_addr = (state_q == S_IF1 || state_q == S_IF2) ? pc_q : addr_q;
  assign mem_cmd  = ctl_q.mem_cmd;
  assign write    = ctl_q.write;
  assign loada    = ctl_q.loada;
  assign loadb    = ctl_q.loadb;
  assign asel     = ctl_q.asel;
  assign bsel     = ctl_q.bsel;
  assign loadc    = ctl_q.loadc;
  assign loads    = ctl_q.loads;
  assign vsel     = ctl_q.vsel;
  assign nsel     = ctl_q.nsel;
  assign halted   = ctl_q.halted;
  assign fault    = ctl_q.fault;

  // Upper datapath bits never address memory; the timeout parameter is dead without the feature.
  logic unused_ok;
  assign unused_ok = ^{datapath_out, 32'(MEM_TIMEOUT)};

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
Parametrised instruction sequencer for the 16-bit RISC core. It owns the instruction register, the program counter, the data-address register and the control FSM, and it drives the datapath's control inputs and the memory command/address bus. It generalises the fixed single-cycle-memory controller in three ways: PC/address width is a parameter, memory accesses use a `mem_ready` wait-state handshake, and it adds STR and conditional branches.

Parameters:
- ADDR_W, 9, width of PC, data-address register and mem_addr.
- RESET_PC, 0, PC value loaded in RST (ADDR_W bits).
- MEM_TIMEOUT, 15, max wait cycles per access (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- read_data  in  16  memory read data; also the IR source.
- mem_ready  in  1  memory has completed the current command this cycle.
- datapath_out  in  16  datapath C register; [ADDR_W-1:0] is the address source.
- N, V, Z  in  1 each  datapath status flags.
- ir  out  16  instruction register, feeds the external decoder.
- pc  out  ADDR_W  program counter, also feeds the datapath.
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE.
- mem_addr  out  ADDR_W  memory address.
- write, loada, loadb, asel, bsel, loadc, loads  out  1 each  datapath controls.
- vsel  out  2  00 C, 01 PC, 10 sximm8, 11 mdata.
- nsel  out  3  one-hot: 001 Rn, 010 Rm, 100 Rd.
- halted  out  1  core stopped.
- fault  out  1  memory timeout (held 0 without the optional feature).

Behaviour:
- Reset is synchronous and active-high. On reset: state=RST, all outputs 0, ir=0, pc=RESET_PC, address register=0. Reset wins in any state, including mid-access and HALT.
- Outputs are a Moore decode of the state register, except mem_addr. Every control not listed for a state is 0.
- mem_addr = pc in IF1/IF2; otherwise mem_addr = the address register.
- Encoding: opcode=ir[15:13], op=ir[12:11], cond=ir[10:8], imm8=ir[7:0] (sign-extended to ADDR_W).
- Fetch and decode path:
  - RST -> IF1.
  - IF1: mem_cmd=READ. Go to IF2 when mem_ready=1, else hold.
  - IF2: mem_cmd=READ, ir<=read_data at the clock edge -> UPC.
  - UPC: pc<=pc+1, wrapping modulo 2^ADDR_W -> DEC.
- DEC dispatch:
  - 110/10 (MOV imm) -> WIMM.
  - 110/00 (MOV reg) -> GB0.
  - 101/11 (MVN) -> GB0.
  - 101/other (ALU) -> GA.
  - 011/00 (LDR) and 100/00 (STR) -> GA3.
  - 001 (branch) -> BR.
  - 111 -> HALT.
  - Anything else -> IF1 (treated as NOP).
- WIMM: write=1, nsel=001, vsel=10 -> IF1.
- GA: loada=1, nsel=001 -> GB.
- GB: loadb=1, nsel=010 -> CMP when op=01, else EX.
- GB0: loadb=1, nsel=010 -> EX0.
- EX: loadc=1, loads=1 -> WB.
- EX0: loadc=1, asel=1 -> WB.
- CMP: loads=1 -> IF1.
- WB: write=1, vsel=00, nsel=100 -> IF1.
- Memory instructions:
  - GA3: loada=1, nsel=001 -> AD3.
  - AD3: bsel=1, loadc=1 (C = Rn + sximm5) -> LA.
  - LA: address register <= datapath_out[ADDR_W-1:0] -> RD for LDR, GD for STR.
  - RD: mem_cmd=READ; hold until mem_ready -> LW.
  - LW: write=1, vsel=11, nsel=100 -> IF1. The memory must keep read_data stable through LW.
  - GD: loadb=1, nsel=100 -> CD.
  - CD: asel=1, loadc=1 (C = Rd) -> WR.
  - WR: mem_cmd=WRITE; hold until mem_ready -> IF1.
- BR: the condition is evaluated on the current N, V, Z.
  - cond 000: always taken.
  - 001: taken when Z.
  - 010: taken when !Z.
  - 011: taken when N!=V.
  - 100: taken when (N!=V)|Z.
  - Other cond values are never taken.
  - Taken: pc<=pc+sext(imm8), wrapping modulo 2^ADDR_W; pc already points past the branch.
  - -> IF1 in both the taken and not-taken cases.
- HALT: halted=1, mem_cmd=NONE, pc frozen. Only reset leaves HALT.
- mem_ready is ignored outside IF1/RD/WR. A mem_ready asserted in the first cycle of an access completes it with zero wait states.

Optional Feature:
- Macro: CPU_SEQ_MEM_TIMEOUT_EN.
- When defined: a per-access counter clears on entry to IF1, RD or WR and increments each cycle mem_ready=0. When the counter reaches MEM_TIMEOUT, the FSM goes to FAULT. FAULT: fault=1, halted=1, mem_cmd=NONE, sticky until reset.
- When undefined: the FSM waits indefinitely, the FAULT state and counter do not exist, and fault is tied to 0.

Test Plan:
- Reset with RESET_PC=0, mem_ready tied 1, mem[0]=MOV R0,#7 (0xD007), mem[1]=HALT (0xE000) -> write pulses 1 cycle with nsel=001, vsel=10; halted=1 with pc=2; PC trace 0,1,2.
- Same program with mem_ready low for 3 cycles per fetch -> IF1 held exactly 3 extra cycles per instruction; ir and pc identical to zero-wait run.
- LDR R1,[R0,#1] (0x6021) with datapath_out=8 in LA, mem[8]=0xABCD -> mem_cmd=01, mem_addr=8; LW asserts write, vsel=11, nsel=100.
- STR R1,[R0,#2] (0x8022) with datapath_out=9 in LA -> mem_cmd=10, mem_addr=9 held until mem_ready; CD asserts asel, loadc.
- BEQ -2 (0x21FE) at pc=5 with Z=1 -> pc=4; with Z=0 -> pc=6. ADDR_W=4, pc=15 at UPC -> pc wraps to 0.
- With CPU_SEQ_MEM_TIMEOUT_EN, MEM_TIMEOUT=15, mem_ready held 0 in IF1 -> fault=1 and halted=1 after 15 wait cycles; reset asserted in FAULT -> all outputs 0, pc=RESET_PC on the next edge.
